// File: rtl/dezigzag.sv
`default_nettype none
// ============================================================================
//  Module   : dezigzag
//  Purpose  : Inverse zigzag reorder for the JPEG decode path. Accepts
//             coefficient pairs in zigzag order and emits each 8x8 block in
//             raster order, one 8-coefficient row per beat. Two 64-entry
//             flop banks ping-pong so one block fills while the other drains.
//  Revision : 1.0 - initial release
// ============================================================================
module dezigzag #(
  parameter int QW = 15
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [1:0][QW-1:0] d,
  input  logic [4:0]         d_cnt,
  input  logic               d_valid,
  output logic               d_hold,
  output logic [7:0][QW-1:0] q,
  output logic [2:0]         q_cnt,
  output logic               q_valid,
  input  logic               q_hold
);

  // Zigzag index to raster index (standard JPEG scan order).
  function automatic logic [5:0] dz(input logic [5:0] k);
    logic [5:0] r;
    case (k)
      6'd0:  r = 6'd0;
      6'd1:  r = 6'd1;
      6'd2:  r = 6'd8;
      6'd3:  r = 6'd16;
      6'd4:  r = 6'd9;
      6'd5:  r = 6'd2;
      6'd6:  r = 6'd3;
      6'd7:  r = 6'd10;
      6'd8:  r = 6'd17;
      6'd9:  r = 6'd24;
      6'd10: r = 6'd32;
      6'd11: r = 6'd25;
      6'd12: r = 6'd18;
      6'd13: r = 6'd11;
      6'd14: r = 6'd4;
      6'd15: r = 6'd5;
      6'd16: r = 6'd12;
      6'd17: r = 6'd19;
      6'd18: r = 6'd26;
      6'd19: r = 6'd33;
      6'd20: r = 6'd40;
      6'd21: r = 6'd48;
      6'd22: r = 6'd41;
      6'd23: r = 6'd34;
      6'd24: r = 6'd27;
      6'd25: r = 6'd20;
      6'd26: r = 6'd13;
      6'd27: r = 6'd6;
      6'd28: r = 6'd7;
      6'd29: r = 6'd14;
      6'd30: r = 6'd21;
      6'd31: r = 6'd28;
      6'd32: r = 6'd35;
      6'd33: r = 6'd42;
      6'd34: r = 6'd49;
      6'd35: r = 6'd56;
      6'd36: r = 6'd57;
      6'd37: r = 6'd50;
      6'd38: r = 6'd43;
      6'd39: r = 6'd36;
      6'd40: r = 6'd29;
      6'd41: r = 6'd22;
      6'd42: r = 6'd15;
      6'd43: r = 6'd23;
      6'd44: r = 6'd30;
      6'd45: r = 6'd37;
      6'd46: r = 6'd44;
      6'd47: r = 6'd51;
      6'd48: r = 6'd58;
      6'd49: r = 6'd59;
      6'd50: r = 6'd52;
      6'd51: r = 6'd45;
      6'd52: r = 6'd38;
      6'd53: r = 6'd31;
      6'd54: r = 6'd39;
      6'd55: r = 6'd46;
      6'd56: r = 6'd53;
      6'd57: r = 6'd60;
      6'd58: r = 6'd61;
      6'd59: r = 6'd54;
      6'd60: r = 6'd47;
      6'd61: r = 6'd55;
      6'd62: r = 6'd62;
      default: r = 6'd63;
    endcase
    return r;
  endfunction

  // Block pointers: bit 0 selects the bank, bit 1 distinguishes full/empty.
  logic [1:0]         wptr_q, wptr_d;
  logic [1:0]         rptr_q, rptr_d;
  logic [2:0]         rd_row_q, rd_row_d;

  // Output row register.
  logic [7:0][QW-1:0] q_q, q_d;
  logic [2:0]         q_cnt_q, q_cnt_d;
  logic               q_valid_q, q_valid_d;

  // Coefficient storage, addressed by raster index.
  logic [QW-1:0]      bank_q [2][64];
  logic [QW-1:0]      bank_d [2][64];

  logic               full;
  logic               empty;
  logic               wr_en;
  logic               load;
  logic [5:0]         wr_addr0;
  logic [5:0]         wr_addr1;

  // Occupancy flags and handshake decisions, all from registered state.
  always_comb begin
    full     = (wptr_q[1] != rptr_q[1]) && (wptr_q[0] == rptr_q[0]);
    empty    = (wptr_q == rptr_q);
    wr_en    = d_valid && !full;
    load     = !empty && (!q_valid_q || !q_hold);
    wr_addr0 = dz({d_cnt, 1'b0});
    wr_addr1 = dz({d_cnt, 1'b1});
  end

  assign d_hold  = full;
  assign q       = q_q;
  assign q_cnt   = q_cnt_q;
  assign q_valid = q_valid_q;

  // Pointer, row counter and output-valid next state.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    rd_row_d  = rd_row_q;
    q_cnt_d   = q_cnt_q;
    q_valid_d = q_valid_q;

    // Block boundaries are taken from d_cnt alone.
    if (wr_en && (d_cnt == 5'd31)) begin
      wptr_d = wptr_q + 2'd1;
    end

    if (load) begin
      q_cnt_d   = rd_row_q;
      q_valid_d = 1'b1;
      rd_row_d  = rd_row_q + 3'd1;
      if (rd_row_q == 3'd7) begin
        rptr_d = rptr_q + 2'd1;
      end
    end else if (!q_hold) begin
      q_valid_d = 1'b0;
    end
  end

  // Bank write of the accepted coefficient pair into the fill bank.
  always_comb begin
    bank_d = bank_q;
    if (wr_en) begin
      bank_d[wptr_q[0]][wr_addr0] = d[0];
      bank_d[wptr_q[0]][wr_addr1] = d[1];
    end
  end

  // Output row data: next raster row of the drain bank on load, else hold.
  always_comb begin
    q_d = q_q;
    if (load) begin
      for (int i = 0; i < 8; i++) begin
        q_d[i] = bank_q[rptr_q[0]][{rd_row_q, 3'(i)}];
      end
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q    <= 2'd0;
      rptr_q    <= 2'd0;
      rd_row_q  <= 3'd0;
      q_cnt_q   <= 3'd0;
      q_valid_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      rd_row_q  <= rd_row_d;
      q_cnt_q   <= q_cnt_d;
      q_valid_q <= q_valid_d;
    end
  end

  // Data registers carry no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
    q_q    <= q_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_dezigzag.sv
`default_nettype none
// Bench for dezigzag: queue-based block model plus directed scenarios.
module tb_dezigzag;
  localparam int QW = 15;
  typedef logic [63:0][QW-1:0] blk_t;

  logic               clk = 1'b0;
  logic               resetn;
  logic [1:0][QW-1:0] d;
  logic [4:0]         d_cnt;
  logic               d_valid;
  logic               d_hold;
  logic [7:0][QW-1:0] q;
  logic [2:0]         q_cnt;
  logic               q_valid;
  logic               q_hold;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;

  always #5 clk = ~clk;

  dezigzag #(.QW(QW)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .d       (d),
    .d_cnt   (d_cnt),
    .d_valid (d_valid),
    .d_hold  (d_hold),
    .q       (q),
    .q_cnt   (q_cnt),
    .q_valid (q_valid),
    .q_hold  (q_hold)
  );

  // Zigzag -> raster by walking the anti-diagonals.
  int zz2r [64];
  initial begin : build_zz
    int k;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
          zz2r[k] = r * 8 + (s - r);
          k++;
        end
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
          zz2r[k] = r * 8 + (s - r);
          k++;
        end
      end
    end
  end

  // Behavioural model: queue of committed raster blocks and an output register.
  blk_t               pend [$];
  blk_t               cur;
  logic               m_qv;
  logic [2:0]         m_qcnt;
  logic [7:0][QW-1:0] m_q;
  int                 m_row;

  initial begin : model
    m_qv = 1'b0; m_qcnt = 3'd0; m_q = '0; m_row = 0; cur = '0;
    forever begin
      @(posedge clk);
      if (!resetn) begin
        pend.delete();
        m_qv = 1'b0; m_qcnt = 3'd0; m_row = 0;
      end else begin
        bit   full_now, ld, commit;
        blk_t done;
        full_now = (pend.size() == 2);
        ld       = (pend.size() > 0) && (!m_qv || !q_hold);
        commit   = 1'b0;
        done     = '0;
        if (d_valid && !full_now) begin
          cur[zz2r[2 * d_cnt]]     = d[0];
          cur[zz2r[2 * d_cnt + 1]] = d[1];
          if (d_cnt == 5'd31) begin
            commit = 1'b1;
            done   = cur;
          end
        end
        if (ld) begin
          for (int i = 0; i < 8; i++) m_q[i] = pend[0][m_row * 8 + i];
          m_qcnt = 3'(m_row);
          m_qv   = 1'b1;
          if (m_row == 7) begin
            m_row = 0;
            void'(pend.pop_front());
          end else begin
            m_row++;
          end
        end else if (!q_hold) begin
          m_qv = 1'b0;
        end
        if (commit) pend.push_back(done);
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  initial begin : compare
    forever begin
      @(negedge clk);
      chk("d_hold", 128'(d_hold), 128'(pend.size() == 2));
      chk("q_valid", 128'(q_valid), 128'(m_qv));
      chk("q_cnt", 128'(q_cnt), 128'(m_qcnt));
      if (m_qv) chk("q", 128'(q), 128'(m_q));
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Stimulus helpers. data[k] holds the coefficient for zigzag index k.
  blk_t data;
  int   exp_r0 [8] = '{0, 1, 5, 6, 14, 15, 27, 28};
  int   exp_r1 [8] = '{2, 4, 7, 13, 16, 26, 29, 42};
  int   exp_r7 [8] = '{35, 36, 48, 49, 57, 58, 62, 63};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_base(input int base);
    for (int k = 0; k < 64; k++) data[k] = QW'(base + k);
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 64; k++) data[k] = QW'($urandom);
  endtask

  task automatic send_beats(input int first, input int last);
    for (int b = first; b <= last; b++) begin
      int budget;
      bit acc;
      d_valid = 1'b1;
      d_cnt   = 5'(b);
      d[0]    = data[2 * b];
      d[1]    = data[2 * b + 1];
      acc     = 1'b0;
      budget  = 0;
      while (!acc && budget < 500) begin
        @(negedge clk);
        acc = !d_hold;
        if (!acc) stall_cnt++;
        @(posedge clk);
        #1;
        budget++;
      end
      if (!acc) chk("beat_accept_timeout", 128'(0), 128'(1));
    end
    d_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((pend.size() != 0 || m_qv) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) chk("drain_timeout", 128'(0), 128'(1));
    step();
  endtask

  initial begin : main
    resetn = 1'b0; d = '0; d_cnt = 5'd0; d_valid = 1'b0; q_hold = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("rst_d_hold", 128'(d_hold), 128'(0));
    chk("rst_q_valid", 128'(q_valid), 128'(0));
    chk("rst_q_cnt", 128'(q_cnt), 128'(0));
    @(posedge clk);
    #1;
    resetn = 1'b1;
    step();

    // Single block, value = zigzag index.
    fill_base(0);
    send_beats(0, 31);
    @(negedge clk);
    chk("lat_not_yet", 128'(q_valid), 128'(0));
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      chk("blk1_q_valid", 128'(q_valid), 128'(1));
      chk("blk1_q_cnt", 128'(q_cnt), 128'(r));
      for (int i = 0; i < 8; i++) begin
        if (r == 0) chk($sformatf("row0[%0d]", i), 128'(q[i]), 128'(exp_r0[i]));
        if (r == 1) chk($sformatf("row1[%0d]", i), 128'(q[i]), 128'(exp_r1[i]));
        if (r == 7) chk($sformatf("row7[%0d]", i), 128'(q[i]), 128'(exp_r7[i]));
      end
    end
    wait_drain();

    // Reset in the middle of a block, then a fresh block.
    fill_rand();
    send_beats(0, 16);
    d_valid = 1'b1; d_cnt = 5'd17; d[0] = data[34]; d[1] = data[35];
    resetn  = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("rst_mid_q_valid", 128'(q_valid), 128'(0));
    chk("rst_mid_d_hold", 128'(d_hold), 128'(0));
    @(posedge clk);
    #1;
    resetn  = 1'b1;
    d_valid = 1'b0;
    step();
    fill_base(2000);
    send_beats(0, 31);
    @(negedge clk);
    @(negedge clk);
    chk("fresh_q_valid", 128'(q_valid), 128'(1));
    chk("fresh_q0", 128'(q[0]), 128'(2000));
    chk("fresh_q2", 128'(q[2]), 128'(2005));
    wait_drain();

    // Full condition: consumer stalled across three blocks.
    q_hold = 1'b1;
    fill_base(3000);
    send_beats(0, 31);
    fill_base(4000);
    send_beats(0, 31);
    @(negedge clk);
    chk("full_d_hold", 128'(d_hold), 128'(1));
    fill_base(5000);
    fork
      send_beats(0, 31);
      begin
        repeat (10) step();
        q_hold = 1'b0;
      end
    join
    wait_drain();

    // Random output stalls during a block.
    fill_rand();
    fork
      send_beats(0, 31);
      begin
        for (int c = 0; c < 80; c++) begin
          q_hold = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    q_hold = 1'b0;
    wait_drain();

    // Streaming 100 back-to-back random blocks.
    stall_cnt = 0;
    for (int b = 0; b < 100; b++) begin
      fill_rand();
      send_beats(0, 31);
    end
    chk("stream_no_hold", 128'(stall_cnt), 128'(0));
    wait_drain();

    // Next block commits on the same edge as the current row-7 load.
    q_hold = 1'b1;
    fill_base(6000);
    send_beats(0, 31);
    fill_base(7000);
    send_beats(0, 30);
    q_hold = 1'b0;
    repeat (6) step();
    send_beats(31, 31);
    @(negedge clk);
    chk("ovl_row7_valid", 128'(q_valid), 128'(1));
    chk("ovl_row7_cnt", 128'(q_cnt), 128'(7));
    chk("ovl_row7_q0", 128'(q[0]), 128'(6035));
    @(negedge clk);
    chk("ovl_next_valid", 128'(q_valid), 128'(1));
    chk("ovl_next_cnt", 128'(q_cnt), 128'(0));
    chk("ovl_next_q0", 128'(q[0]), 128'(7000));
    chk("ovl_next_q1", 128'(q[1]), 128'(7001));
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
